// File: rtl/mat2x2_pkg.sv
// Shared definitions for the 2x2 8-bit matrix multiplier datapath:
// element/matrix widths, loader FSM encoding and an element packing helper.
package mat2x2_pkg;

    localparam int ELEM_W = 8;
    localparam int MAT_W  = 32;
    localparam int N_ELEM = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } ld_state_e;

    // Replace element slot idx of a row-major matrix word; slot 0 is x00 in the MSBs.
    function automatic logic [MAT_W-1:0] put_elem(input logic [MAT_W-1:0] w,
                                                  input logic [1:0]       idx,
                                                  input logic [ELEM_W-1:0] e);
        logic [MAT_W-1:0] r;
        r = w;
        case (idx)
            2'd0:    r[3*ELEM_W +: ELEM_W] = e;
            2'd1:    r[2*ELEM_W +: ELEM_W] = e;
            2'd2:    r[1*ELEM_W +: ELEM_W] = e;
            default: r[0*ELEM_W +: ELEM_W] = e;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mat_idle_timer.sv
// Idle-cycle counter for partial frames. clr has priority over en; expire is
// high on the en cycle that brings the idle count to TIMEOUT_CYC.
// TIMEOUT_CYC = 0 ties expire low and builds no counter.
module mat_idle_timer #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_tie;
            assign unused_tie = &{1'b0, clk, rst_n, clr, en};
            assign expire     = 1'b0;
        end else begin : g_on
            // Counter only has to hold 0..TIMEOUT_CYC-1 idle cycles already seen.
            localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

            logic [TW-1:0] cnt_q, cnt_d;

            assign expire = en && !clr && (cnt_q == LAST);

            // Next idle count: clear, advance, or restart after expiry.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
                end
            end

            // Idle count register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

endmodule

// File: rtl/mat2x2_operand_loader.sv
// Byte-stream loader for the 2x2 matrix multiplier: packs 4 bytes of A then
// 4 bytes of B row-major (first byte in MSB) and holds the pair until the
// consumer takes it.
// Optional feature macro: MAT_LOAD_CNT_EN adds the pair_cnt handshake counter.
//
// Handshakes: a byte transfers on a rising edge where s_valid && s_ready;
// a pair transfers where m_valid && m_ready. Valid sources never depend on
// ready; s_ready is low during reset, during flush and while holding a pair.
module mat2x2_operand_loader
    import mat2x2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ELEM_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [MAT_W-1:0]  m_data1,
    output logic [MAT_W-1:0]  m_data2,
    output logic              busy,
    output logic              timeout_err,
    output ld_state_e         dbg_state
`ifdef MAT_LOAD_CNT_EN
    ,
    output logic [CNT_W-1:0]  pair_cnt
`endif
);

    ld_state_e        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [MAT_W-1:0] a_q, a_d, b_q, b_d;
    logic             m_valid_q, m_valid_d;
    logic             busy_q, busy_d;
    logic             terr_q, terr_d;
    logic             accept, in_load, expire;

`ifdef MAT_LOAD_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign pair_cnt = cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    assign s_ready     = rst_n && !flush && (state_q != HOLD);
    assign accept      = s_valid && s_ready;
    assign in_load     = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign m_valid     = m_valid_q;
    assign m_data1     = a_q;
    assign m_data2     = b_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

    mat_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush || accept || !in_load),
        .en     (in_load && !accept),
        .expire (expire)
    );

    // Loader FSM next state: flush first, then accept, then timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        terr_d  = 1'b0;
`ifdef MAT_LOAD_CNT_EN
        cnt_d   = cnt_q;
`endif
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d     = put_elem(a_q, 2'd0, s_data);
                        idx_d   = 2'd1;
                        state_d = LOAD_A;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        if (state_q == LOAD_A) a_d = put_elem(a_q, idx_q, s_data);
                        else                   b_d = put_elem(b_q, idx_q, s_data);
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
                    end else if (expire) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        a_d     = '0;
                        b_d     = '0;
                        terr_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state_d = IDLE;
`ifdef MAT_LOAD_CNT_EN
                        cnt_d   = cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        m_valid_d = (state_d == HOLD);
        busy_d    = (state_d != IDLE);
    end

    // Loader FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
`ifdef MAT_LOAD_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
`ifdef MAT_LOAD_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mat2x2_operand_loader.sv
// Bench for mat2x2_operand_loader: directed scenarios plus random traffic,
// all checked cycle by cycle against a frame-level reference model.
module tb_mat2x2_operand_loader;

  localparam int T_CYC = 4;
  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n, flush, s_valid, s_ready, m_valid, m_ready, busy, timeout_err;
  logic [7:0]  s_data;
  logic [31:0] m_data1, m_data2;
  logic [1:0]  dbg_state;
`ifdef MAT_LOAD_CNT_EN
  logic [CNT_W-1:0] pair_cnt;
`endif

  always #5 clk = ~clk;

  mat2x2_operand_loader #(
    .TIMEOUT_CYC (T_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data1     (m_data1),
    .m_data2     (m_data2),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
`ifdef MAT_LOAD_CNT_EN
    ,
    .pair_cnt    (pair_cnt)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  r_m[8];
  int          n_m, idle_m, cnt_m;
  bit          hold_m, terr_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (hold_m)        return 2'd3;
    else if (n_m == 0) return 2'd0;
    else if (n_m < 4)  return 2'd1;
    else               return 2'd2;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 8; i++) r_m[i] = 8'h00;
    n_m    = 0;
    idle_m = 0;
    hold_m = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check("m_valid", m_valid, hold_m);
    check("m_data1", m_data1, {r_m[0], r_m[1], r_m[2], r_m[3]});
    check("m_data2", m_data2, {r_m[4], r_m[5], r_m[6], r_m[7]});
    check("busy", busy, (n_m > 0) || hold_m);
    check("timeout_err", timeout_err, terr_m);
    check("state", dbg_state, exp_state());
`ifdef MAT_LOAD_CNT_EN
    check("pair_cnt", pair_cnt, cnt_m);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: check outputs, drive inputs, advance the model, wait.
  task automatic step(input logic v, input logic [7:0] d, input logic mr, input logic fl);
    check_outputs();
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    #1;
    check("s_ready", s_ready, !fl && !hold_m);
    terr_m = 0;
    if (fl) begin
      zero_model();
    end else if (hold_m) begin
      if (mr) begin
        if (exp_q.size() == 0) check("frame_q_empty", 1, 0);
        else                   check("frame", {m_data1, m_data2}, exp_q.pop_front());
        hold_m = 0;
        n_m    = 0;
        cnt_m  = (cnt_m + 1) % (1 << CNT_W);
      end
    end else if (v) begin
      r_m[n_m] = d;
      n_m++;
      idle_m = 0;
      if (n_m == 8) begin
        hold_m = 1;
        exp_q.push_back({r_m[0], r_m[1], r_m[2], r_m[3], r_m[4], r_m[5], r_m[6], r_m[7]});
      end
    end else if (n_m > 0) begin
      idle_m++;
      if (idle_m == T_CYC) begin
        for (int i = 0; i < 8; i++) r_m[i] = 8'h00;
        n_m    = 0;
        idle_m = 0;
        terr_m = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b1, bytes[63-8*i -: 8], mr, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
  task automatic do_reset();
    s_valid = 0; s_data = 0; m_ready = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data1", m_data1, 0);
    check("rst_m_data2", m_data2, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_state", dbg_state, 0);
`ifdef MAT_LOAD_CNT_EN
    check("rst_pair_cnt", pair_cnt, 0);
`endif
    zero_model();
    terr_m = 0;
    cnt_m  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    rst_n = 1'b1; s_valid = 0; s_data = 0; m_ready = 0; flush = 0;
    @(negedge clk);
    do_reset();

    // 1: back-to-back frame, consumer always ready
    send_bytes(64'h0102030405060708, 8, 1'b1);
    check("t1_valid", m_valid, 1);
    check("t1_a", m_data1, 32'h01020304);
    check("t1_b", m_data2, 32'h05060708);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_after_hs", m_valid, 0);

    // 2: stalled consumer, input keeps offering bytes
    send_bytes(64'h0102030405060708, 8, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      check("t2_hold_a", m_data1, 32'h01020304);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_idle", dbg_state, 0);

    // 3: partial frame times out after T_CYC idle cycles
    send_bytes(64'h0A0B0C0000000000, 3, 1'b1);
    for (int i = 0; i < T_CYC; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_terr", timeout_err, 1);
    check("t3_cleared", m_data1, 0);
    send_bytes(64'h1112131415161718, 8, 1'b0);
    check("t3_a", m_data1, 32'h11121314);
    check("t3_b", m_data2, 32'h15161718);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4: flush after 6 bytes; next frame starts at a00
    send_bytes(64'hF1F2F3F4F5F60000, 6, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    check("t4_flushed", busy, 0);
    send_bytes(64'hA0A1A2A3B0B1B2B3, 8, 1'b0);
    check("t4_a", m_data1, 32'hA0A1A2A3);
    check("t4_b", m_data2, 32'hB0B1B2B3);
    step(1'b0, 8'h00, 1'b1, 1'b1);  // flush during hold: handshake not counted

    // 5: reset mid-LOAD_B, then a clean frame
    send_bytes(64'h2122232425262728, 6, 1'b1);
    do_reset();
    send_bytes(64'h3132333435363738, 8, 1'b1);
    check("t5_a", m_data1, 32'h31323334);
    check("t5_b", m_data2, 32'h35363738);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef MAT_LOAD_CNT_EN
    // 6: handshake counter wraps at 2^CNT_W
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send_bytes({$urandom, $urandom}, 8, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_pair_cnt", pair_cnt, (f + 1) % 4);
    end
`endif

    // random traffic: gaps long enough to time out, stalls and rare flushes
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (gap == 0 && $urandom_range(0, 49) == 0) gap = $urandom_range(3, 6);
      if (gap > 0) begin
        gap--;
        step(1'b0, 8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 99) == 0));
      end else begin
        step(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
      end
    end
    check_outputs();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
